drum_word_addr_sync: RTL and testbench
======================================

Name: drum_word_addr_sync

Overview:
- Downstream consumer of the drum timing tracks Z2 (sector mark) and Z3 (serial address).
- Locks a 40-bit word frame to the Z2 long mark and tracks bit position within the word.
- Assembles the 7-bit serial word address carried on Z3 and flags when it equals a requested target address.
- Output feeds the T-state logic that opens memory read/write windows.

Parameters:
WORD_BITS, 40, bit times per drum word
ADR_BITS, 7, serial address width
MARK_BIT, 31, bit number of the first high sample of the Z2 long mark
ADR_START, 32, bit number carrying address bit 0 on Z3
MIN_LOW, 8, consecutive low Z2 samples required before a 0->1 edge is a frame mark
LOCK_FRAMES, 2, consecutive good marks needed to assert LOCK

Ports:
Z1  in  1  bit clock, 1 us period; all state updates on rising edge
_W2  in  1  master clear; asynchronous, active-low
Z2  in  1  timing track: high bits 31-33 and 38-39 of each word
Z3  in  1  address track: adr[0..6] LSB first at bits 32-38, 0 elsewhere
TGT  in  7  requested word address
BITNO  out  6  bit number (0..39) of the current sample
LOCK  out  1  frame locked
ADR  out  7  last assembled address
ADR_STB  out  1  one-clock pulse when ADR updates
MATCH  out  1  ADR==TGT, held for the word following capture
SYNC_ERR  out  1  one-clock pulse, expected mark missing
SEQ_ERR  out  1  one-clock pulse, address not previous+1 mod 128

Behaviour:
- Reset (_W2 low, any time, including mid-word): all outputs 0, state HUNT, low-run counter 0, shift register 0, previous-address-valid flag cleared. Release takes effect on the next Z1 rising edge.
- Z2 and Z3 are sampled on the Z1 rising edge. Both change on Z1 falling edges, so the sample is mid-bit.
- Low-run counter:
  - counts consecutive Z2=0 samples;
  - saturates at MIN_LOW;
  - clears on Z2=1.
- Mark: Z2=1 sample with the previous sample 0 and low-run >= MIN_LOW.
- States:
  - HUNT:
    - BITNO free-runs mod 40, LOCK=0.
    - On a mark: BITNO forced so that the mark sample is bit 31 (next sample is 32), good-mark count = 1, go to ALIGN.
  - ALIGN:
    - BITNO increments, wrapping 39->0.
    - At BITNO==31, a mark increments the good-mark count. Reaching LOCK_FRAMES -> LOCKED, LOCK=1 from the next cycle.
    - At BITNO==31, no mark -> back to HUNT; SYNC_ERR is not pulsed.
  - LOCKED:
    - At BITNO==31 with no mark: SYNC_ERR pulses next cycle, LOCK drops, state HUNT, previous-valid cleared.
    - Marks seen at any other position while LOCKED are ignored.
- Address assembly (ALIGN and LOCKED):
  - At BITNO 32..38, Z3 is shifted in LSB first: shift right, new bit into bit 6.
  - On the sample at BITNO 38, if LOCK=1:
    - ADR <= assembled value, ADR_STB=1 during bit 39 only;
    - MATCH <= (assembled==TGT), held until the next ADR_STB;
    - if previous-valid and assembled != (ADR+1) mod 128, SEQ_ERR pulses with ADR_STB;
    - previous-valid is then set.
  - If LOCK=0 at bit 38: nothing is captured.
  - The shift register clears at BITNO 0.
- Changes of TGT between captures do not affect MATCH until the next capture.
- Wrap: 127->0 is a legal sequence and raises no SEQ_ERR.
- Simultaneous lock loss and capture are impossible: capture happens at bit 38, the check at bit 31.

Test Plan:
1. Reset, then drive standard tracks with addresses 1,2,3...:
   - first mark in word adr=1 -> ALIGN;
   - second mark -> LOCK=1;
   - first ADR_STB with ADR=2, then 3, 4 at 40-bit spacing;
   - SEQ_ERR stays 0.
2. TGT=5 -> MATCH=1 only for the word after ADR=5 is captured, 0 after ADR=6.
3. Run addresses through 126,127,0,1 -> ADR_STB values follow exactly; no SEQ_ERR at the 127->0 wrap.
4. Hold Z2 low for one full word while LOCKED:
   - SYNC_ERR one-clock pulse one cycle after bit 31;
   - LOCK=0;
   - relock after 2 good marks;
   - the first capture after relock raises no SEQ_ERR.
5. Skip address 10 (send 9 then 11) -> ADR_STB with ADR=11 and SEQ_ERR=1 in the same cycle.
6. Assert _W2 low at bit 35 of a locked word:
   - all outputs 0 immediately, with no Z1 edge needed;
   - after release, no ADR_STB until a new lock;
   - the next ADR_STB is in the second marked word after release.

Source files
------------

// File: rtl/drum_word_addr_sync.sv
// Word-frame synchroniser for the drum timing tracks: locks bit position to the Z2
// long mark and assembles/compares the serial word address carried on Z3.
module drum_word_addr_sync #(
  parameter int WORD_BITS   = 40,
  parameter int ADR_BITS    = 7,
  parameter int MARK_BIT    = 31,
  parameter int ADR_START   = 32,
  parameter int MIN_LOW     = 8,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                Z1,
  input  logic                _W2,
  input  logic                Z2,
  input  logic                Z3,
  input  logic [ADR_BITS-1:0] TGT,
  output logic [5:0]          BITNO,
  output logic                LOCK,
  output logic [ADR_BITS-1:0] ADR,
  output logic                ADR_STB,
  output logic                MATCH,
  output logic                SYNC_ERR,
  output logic                SEQ_ERR
);

  localparam int LW = $clog2(MIN_LOW + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [5:0]          WORD_LAST = 6'(WORD_BITS - 1);
  localparam logic [5:0]          MARK_B    = 6'(MARK_BIT);
  localparam logic [5:0]          MARK_NEXT = 6'(MARK_BIT + 1);
  localparam logic [5:0]          ADR_FIRST = 6'(ADR_START);
  localparam logic [5:0]          ADR_LAST  = 6'(ADR_START + ADR_BITS - 1);
  localparam logic [LW-1:0]       MIN_LOW_C = LW'(MIN_LOW);
  localparam logic [LW-1:0]       LOW_ONE   = LW'(1);
  localparam logic [GW-1:0]       LOCK_C    = GW'(LOCK_FRAMES);
  localparam logic [GW-1:0]       GOOD_ONE  = GW'(1);
  localparam logic [ADR_BITS-1:0] ADR_ONE   = ADR_BITS'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [5:0]          bitno_r, bitno_s;
  logic [LW-1:0]       lowrun_r, lowrun_s;
  logic                z2_prev_r;
  logic [GW-1:0]       good_r, good_s, good_inc_s;
  logic [ADR_BITS-1:0] shift_r, shift_s, asm_s;
  logic [ADR_BITS-1:0] adr_r, adr_s;
  logic                lock_r, lock_s;
  logic                stb_r, stb_s;
  logic                match_r, match_s;
  logic                sync_r, sync_s;
  logic                seq_r, seq_s;
  logic                pv_r, pv_s;
  logic                mark_s, at_mark_s, in_adr_s;

  assign mark_s     = Z2 && !z2_prev_r && (lowrun_r >= MIN_LOW_C);
  assign at_mark_s  = (bitno_r == MARK_B);
  assign in_adr_s   = (bitno_r >= ADR_FIRST) && (bitno_r <= ADR_LAST);
  assign asm_s      = {Z3, shift_r[ADR_BITS-1:1]};
  assign good_inc_s = good_r + GOOD_ONE;

  // Next-state, frame tracking and address capture
  always_comb begin
    state_s  = state_r;
    bitno_s  = (bitno_r == WORD_LAST) ? 6'd0 : bitno_r + 6'd1;
    good_s   = good_r;
    lock_s   = lock_r;
    adr_s    = adr_r;
    match_s  = match_r;
    pv_s     = pv_r;
    stb_s    = 1'b0;
    sync_s   = 1'b0;
    seq_s    = 1'b0;

    if (Z2) begin
      lowrun_s = {LW{1'b0}};
    end else if (lowrun_r < MIN_LOW_C) begin
      lowrun_s = lowrun_r + LOW_ONE;
    end else begin
      lowrun_s = lowrun_r;
    end

    if (bitno_r == 6'd0) begin
      shift_s = {ADR_BITS{1'b0}};
    end else begin
      shift_s = shift_r;
    end

    case (state_r)
      HUNT: begin
        lock_s = 1'b0;
        if (mark_s) begin
          state_s = ALIGN;
          bitno_s = MARK_NEXT;
          good_s  = GOOD_ONE;
        end else begin
          state_s = HUNT;
        end
      end
      ALIGN: begin
        if (at_mark_s && mark_s) begin
          good_s = good_inc_s;
          if (good_inc_s >= LOCK_C) begin
            state_s = LOCKED;
            lock_s  = 1'b1;
          end else begin
            state_s = ALIGN;
          end
        end else if (at_mark_s) begin
          state_s = HUNT;
          good_s  = {GW{1'b0}};
        end else begin
          state_s = ALIGN;
        end
      end
      LOCKED: begin
        // Only the mark position is checked; stray marks elsewhere are ignored
        if (at_mark_s && !mark_s) begin
          state_s = HUNT;
          lock_s  = 1'b0;
          sync_s  = 1'b1;
          pv_s    = 1'b0;
          good_s  = {GW{1'b0}};
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s = HUNT;
        lock_s  = 1'b0;
        good_s  = {GW{1'b0}};
      end
    endcase

    if ((state_r != HUNT) && in_adr_s) begin
      shift_s = asm_s;
      if ((bitno_r == ADR_LAST) && lock_r) begin
        adr_s   = asm_s;
        stb_s   = 1'b1;
        match_s = (asm_s == TGT);
        seq_s   = pv_r && (asm_s != (adr_r + ADR_ONE));
        pv_s    = 1'b1;
      end else begin
        adr_s = adr_r;
      end
    end else begin
      shift_s = shift_s;
    end
  end

  // State and output registers, cleared asynchronously by master clear
  always_ff @(posedge Z1 or negedge _W2) begin
    if (!_W2) begin
      state_r   <= HUNT;
      bitno_r   <= 6'd0;
      lowrun_r  <= {LW{1'b0}};
      z2_prev_r <= 1'b0;
      good_r    <= {GW{1'b0}};
      shift_r   <= {ADR_BITS{1'b0}};
      adr_r     <= {ADR_BITS{1'b0}};
      lock_r    <= 1'b0;
      stb_r     <= 1'b0;
      match_r   <= 1'b0;
      sync_r    <= 1'b0;
      seq_r     <= 1'b0;
      pv_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      bitno_r   <= bitno_s;
      lowrun_r  <= lowrun_s;
      z2_prev_r <= Z2;
      good_r    <= good_s;
      shift_r   <= shift_s;
      adr_r     <= adr_s;
      lock_r    <= lock_s;
      stb_r     <= stb_s;
      match_r   <= match_s;
      sync_r    <= sync_s;
      seq_r     <= seq_s;
      pv_r      <= pv_s;
    end
  end

  assign BITNO    = bitno_r;
  assign LOCK     = lock_r;
  assign ADR      = adr_r;
  assign ADR_STB  = stb_r;
  assign MATCH    = match_r;
  assign SYNC_ERR = sync_r;
  assign SEQ_ERR  = seq_r;

endmodule

// File: tb/tb_drum_word_addr_sync.sv
// Directed bench: generates standard Z2/Z3 drum tracks word by word and checks
// lock, address strobes, match, sequence and sync errors against hand-derived values.
module tb_drum_word_addr_sync;

  logic       Z1 = 1'b0;
  logic       _W2 = 1'b0;
  logic       Z2 = 1'b0;
  logic       Z3 = 1'b0;
  logic [6:0] TGT = 7'd0;
  logic [5:0] BITNO;
  logic       LOCK, ADR_STB, MATCH, SYNC_ERR, SEQ_ERR;
  logic [6:0] ADR;

  drum_word_addr_sync dut (
    .Z1(Z1), ._W2(_W2), .Z2(Z2), .Z3(Z3), .TGT(TGT),
    .BITNO(BITNO), .LOCK(LOCK), .ADR(ADR), .ADR_STB(ADR_STB),
    .MATCH(MATCH), .SYNC_ERR(SYNC_ERR), .SEQ_ERR(SEQ_ERR)
  );

  always #5 Z1 = ~Z1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] word_adr = 7'd1;
  logic       drop_z2  = 1'b0;
  int         cyc      = 0;
  int         bitno_bad = 0;

  int         stb_n, seq_n, sync_n, stb_bit, sync_bit, stb_cyc, prev_cyc;
  logic [6:0] stb_adr;
  logic       stb_seq, stb_match, match_mid, lock_end;
  logic [5:0] bitno31;

  task automatic drive_bit(input int b);
    @(negedge Z1);
    Z2 = !drop_z2 && ((b >= 31 && b <= 33) || b == 38 || b == 39);
    Z3 = (b >= 32 && b <= 38) ? word_adr[b-32] : 1'b0;
    @(posedge Z1);
    #1;
  endtask

  task automatic run_bits(input int first, input int last);
    stb_n = 0; seq_n = 0; sync_n = 0; stb_bit = -1; sync_bit = -1;
    stb_adr = 7'd0; stb_seq = 1'b0; stb_match = 1'b0; match_mid = 1'b0; bitno31 = 6'd0;
    for (int b = first; b <= last; b++) begin
      drive_bit(b);
      cyc++;
      if (ADR_STB === 1'b1) begin
        stb_n++; stb_adr = ADR; stb_seq = SEQ_ERR; stb_bit = b; stb_cyc = cyc; stb_match = MATCH;
      end
      if (SEQ_ERR === 1'b1) seq_n++;
      if (SYNC_ERR === 1'b1) begin sync_n++; sync_bit = b; end
      if (b == 20) match_mid = MATCH;
      if (b == 31) bitno31 = BITNO;
      if (LOCK === 1'b1 && BITNO !== 6'((b + 1) % 40)) bitno_bad++;
    end
    lock_end = LOCK;
  endtask

  task automatic run_word();
    run_bits(0, 39);
    word_adr = word_adr + 7'd1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Z1);
    #1;
    n_checks++; if (BITNO !== 6'd0)    begin n_fail++; $display("FAIL rst_bitno: got %0d expected 0", BITNO); end
    n_checks++; if (LOCK !== 1'b0)     begin n_fail++; $display("FAIL rst_lock: got %0b expected 0", LOCK); end
    n_checks++; if (ADR !== 7'd0)      begin n_fail++; $display("FAIL rst_adr: got %0d expected 0", ADR); end
    n_checks++; if (ADR_STB !== 1'b0)  begin n_fail++; $display("FAIL rst_stb: got %0b expected 0", ADR_STB); end
    n_checks++; if (MATCH !== 1'b0)    begin n_fail++; $display("FAIL rst_match: got %0b expected 0", MATCH); end
    n_checks++; if (SYNC_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_sync: got %0b expected 0", SYNC_ERR); end
    n_checks++; if (SEQ_ERR !== 1'b0)  begin n_fail++; $display("FAIL rst_seq: got %0b expected 0", SEQ_ERR); end
    _W2 = 1'b1;
  endtask

  task automatic test_lock();
    word_adr = 7'd1;
    run_word();
    n_checks++; if (bitno31 !== 6'd32) begin n_fail++; $display("FAIL align_bitno: got %0d expected 32", bitno31); end
    n_checks++; if (lock_end !== 1'b0) begin n_fail++; $display("FAIL align_nolock: got %0b expected 0", lock_end); end
    n_checks++; if (stb_n !== 0)       begin n_fail++; $display("FAIL align_nostb: got %0d expected 0", stb_n); end
    run_word();
    n_checks++; if (lock_end !== 1'b1) begin n_fail++; $display("FAIL lock2: got %0b expected 1", lock_end); end
    n_checks++; if (stb_n !== 1 || stb_adr !== 7'd2) begin n_fail++; $display("FAIL stb_adr2: got n=%0d adr=%0d expected n=1 adr=2", stb_n, stb_adr); end
    n_checks++; if (stb_bit !== 38)    begin n_fail++; $display("FAIL stb_pos: got %0d expected 38", stb_bit); end
    run_word();
    prev_cyc = stb_cyc;
    n_checks++; if (stb_adr !== 7'd3)  begin n_fail++; $display("FAIL stb_adr3: got %0d expected 3", stb_adr); end
    run_word();
    n_checks++; if (stb_adr !== 7'd4)  begin n_fail++; $display("FAIL stb_adr4: got %0d expected 4", stb_adr); end
    n_checks++; if (stb_cyc - prev_cyc !== 40) begin n_fail++; $display("FAIL stb_spacing: got %0d expected 40", stb_cyc - prev_cyc); end
    n_checks++; if (seq_n !== 0 || stb_seq !== 1'b0) begin n_fail++; $display("FAIL lock_noseq: got %0d expected 0", seq_n); end
  endtask

  task automatic test_match();
    TGT = 7'd5;
    run_word();
    n_checks++; if (stb_adr !== 7'd5 || stb_match !== 1'b1) begin n_fail++; $display("FAIL match5: got adr=%0d match=%0b expected adr=5 match=1", stb_adr, stb_match); end
    TGT = 7'd7;
    run_word();
    n_checks++; if (match_mid !== 1'b1) begin n_fail++; $display("FAIL match_hold: got %0b expected 1", match_mid); end
    n_checks++; if (stb_adr !== 7'd6 || stb_match !== 1'b0) begin n_fail++; $display("FAIL match6: got adr=%0d match=%0b expected adr=6 match=0", stb_adr, stb_match); end
    run_word();
    n_checks++; if (stb_adr !== 7'd7 || stb_match !== 1'b1) begin n_fail++; $display("FAIL match7: got adr=%0d match=%0b expected adr=7 match=1", stb_adr, stb_match); end
  endtask

  task automatic test_skip();
    run_word();
    run_word();
    n_checks++; if (stb_adr !== 7'd9 || seq_n !== 0) begin n_fail++; $display("FAIL skip_adr9: got adr=%0d seq=%0d expected adr=9 seq=0", stb_adr, seq_n); end
    word_adr = 7'd11;
    run_word();
    n_checks++; if (stb_adr !== 7'd11 || stb_seq !== 1'b1) begin n_fail++; $display("FAIL skip_seq: got adr=%0d seq=%0b expected adr=11 seq=1", stb_adr, stb_seq); end
    n_checks++; if (seq_n !== 1) begin n_fail++; $display("FAIL skip_seq_cnt: got %0d expected 1", seq_n); end
  endtask

  task automatic test_sync_loss();
    drop_z2 = 1'b1;
    run_word();
    drop_z2 = 1'b0;
    n_checks++; if (sync_n !== 1 || sync_bit !== 31) begin n_fail++; $display("FAIL sync_pulse: got n=%0d bit=%0d expected n=1 bit=31", sync_n, sync_bit); end
    n_checks++; if (lock_end !== 1'b0 || stb_n !== 0) begin n_fail++; $display("FAIL sync_unlock: got lock=%0b stb=%0d expected 0 0", lock_end, stb_n); end
    word_adr = 7'd124;
    run_word();
    n_checks++; if (lock_end !== 1'b0 || stb_n !== 0 || sync_n !== 0) begin n_fail++; $display("FAIL relock_align: got lock=%0b stb=%0d sync=%0d expected 0 0 0", lock_end, stb_n, sync_n); end
    run_word();
    n_checks++; if (lock_end !== 1'b1 || stb_adr !== 7'd125) begin n_fail++; $display("FAIL relock: got lock=%0b adr=%0d expected 1 125", lock_end, stb_adr); end
    n_checks++; if (seq_n !== 0) begin n_fail++; $display("FAIL relock_noseq: got %0d expected 0", seq_n); end
  endtask

  task automatic test_wrap();
    logic [6:0] exp_adr;
    exp_adr = 7'd126;
    for (int w = 0; w < 4; w++) begin
      run_word();
      n_checks++; if (stb_n !== 1 || stb_adr !== exp_adr || seq_n !== 0) begin n_fail++; $display("FAIL wrap_%0d: got adr=%0d seq=%0d expected adr=%0d seq=0", w, stb_adr, seq_n, exp_adr); end
      exp_adr = exp_adr + 7'd1;
    end
    n_checks++; if (bitno_bad !== 0) begin n_fail++; $display("FAIL bitno_track: got %0d bad samples expected 0", bitno_bad); end
  endtask

  task automatic test_reset_mid();
    run_bits(0, 34);
    n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL pre_rst_lock: got %0b expected 1", LOCK); end
    #1;
    _W2 = 1'b0;
    #1;
    n_checks++; if (LOCK !== 1'b0 || ADR !== 7'd0 || BITNO !== 6'd0) begin n_fail++; $display("FAIL midrst_regs: got lock=%0b adr=%0d bitno=%0d expected 0 0 0", LOCK, ADR, BITNO); end
    n_checks++; if (ADR_STB !== 1'b0 || MATCH !== 1'b0 || SYNC_ERR !== 1'b0 || SEQ_ERR !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got stb=%0b match=%0b sync=%0b seq=%0b expected 0", ADR_STB, MATCH, SYNC_ERR, SEQ_ERR); end
    run_bits(35, 36);
    _W2 = 1'b1;
    run_bits(37, 39);
    word_adr = word_adr + 7'd1;
    n_checks++; if (stb_n !== 0 || lock_end !== 1'b0) begin n_fail++; $display("FAIL post_rst_tail: got stb=%0d lock=%0b expected 0 0", stb_n, lock_end); end
    run_word();
    n_checks++; if (stb_n !== 0 || lock_end !== 1'b0) begin n_fail++; $display("FAIL post_rst_first: got stb=%0d lock=%0b expected 0 0", stb_n, lock_end); end
    run_word();
    n_checks++; if (stb_n !== 1 || stb_adr !== 7'd4 || lock_end !== 1'b1) begin n_fail++; $display("FAIL post_rst_relock: got stb=%0d adr=%0d lock=%0b expected 1 4 1", stb_n, stb_adr, lock_end); end
    n_checks++; if (seq_n !== 0) begin n_fail++; $display("FAIL post_rst_noseq: got %0d expected 0", seq_n); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_match();
    test_skip();
    test_sync_loss();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
